// File: rtl/updn_disp_pkg.sv
// Shared types and constants for the up/down counter display stage:
// conversion FSM states, segment patterns and the double-dabble nibble adjust.
package updn_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_t;

    localparam int BCD_SHIFTS = 5;

    // Active-high patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder with blanking and
// selectable output polarity.
module seg7_decode
    import updn_disp_pkg::*;
#(
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            pattern = SEG_TABLE[digit];
        end
        seg = COMMON_ANODE ? ~pattern : pattern;
    end

endmodule

// File: rtl/updn_seg_display.sv
// Converts the 5-bit counter value to two BCD digits with a sequential
// double-dabble and scans them onto a 2-digit multiplexed 7-segment display.
module updn_seg_display
    import updn_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] Q,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       DP
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_OFF  = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic [1:0]      AN_OFF   = COMMON_ANODE ? 2'b11 : 2'b00;

    logic [4:0]       q_s_reg;
    logic [4:0]       last_reg;
    logic [4:0]       conv_reg;
    logic [12:0]      sr_reg;
    logic [12:0]      sr_adj;
    logic [2:0]       bit_cnt_reg;
    logic [3:0]       ones_reg;
    logic [3:0]       tens_reg;
    conv_state_t      state_reg;
    conv_state_t      state_next;
    logic             load_en;
    logic             shift_en;
    logic             commit_en;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic             sel_reg;
    logic [3:0]       disp_digit;
    logic             disp_blank;
    logic [6:0]       seg_next;
    logic [1:0]       an_next;
    logic [6:0]       seg_reg;
    logic [1:0]       an_reg;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (q_s_reg != last_reg) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (bit_cnt_reg == 3'(BCD_SHIFTS)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath strobes fire on the edge that enters each state, so a change
    // seen by IDLE is committed six edges after it is loaded.
    always_comb begin
        load_en   = (state_reg == IDLE) && (q_s_reg != last_reg);
        shift_en  = (state_reg == LOAD) ||
                    ((state_reg == SHIFT) && (bit_cnt_reg != 3'(BCD_SHIFTS)));
        commit_en = (state_reg == SHIFT) && (bit_cnt_reg == 3'(BCD_SHIFTS));
    end

    assign sr_adj = {dd_adjust(sr_reg[12:9]), dd_adjust(sr_reg[8:5]), sr_reg[4:0]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_s_reg     <= '0;
            last_reg    <= '0;
            conv_reg    <= '0;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            ones_reg    <= '0;
            tens_reg    <= '0;
        end else begin
            q_s_reg <= Q;
            if (load_en) begin
                sr_reg      <= {8'b0, q_s_reg};
                conv_reg    <= q_s_reg;
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                sr_reg      <= {sr_adj[11:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            // Both digits update together so a frame never mixes old and new.
            if (commit_en) begin
                tens_reg <= sr_reg[12:9];
                ones_reg <= sr_reg[8:5];
                last_reg <= conv_reg;
            end
        end
    end

    // ---------------- digit scan ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan_cnt_reg <= '0;
            sel_reg      <= 1'b0;
        end else if (scan_cnt_reg == CNT_LAST) begin
            scan_cnt_reg <= '0;
            sel_reg      <= ~sel_reg;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + CNT_W'(1);
        end
    end

    assign disp_digit = sel_reg ? tens_reg : ones_reg;
    assign disp_blank = sel_reg && (tens_reg == 4'd0);

    seg7_decode #(
        .COMMON_ANODE(COMMON_ANODE)
    ) u_decode (
        .digit(disp_digit),
        .blank(disp_blank),
        .seg  (seg_next)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_an
        assign an_next[gi] = (sel_reg == 1'(gi)) ^ COMMON_ANODE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            seg_reg <= SEG_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign SEG = seg_reg;
    assign AN  = an_reg;
    assign DP  = COMMON_ANODE;

endmodule

// File: tb/tb_updn_seg_display.sv
// Randomized scoreboard bench for updn_seg_display with a cycle-level
// behavioural model of conversion timing and digit scanning.
module tb_updn_seg_display;

    localparam int SCAN_DIV = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] q;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t exp_q[$];

    logic [6:0] seg_tab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    updn_seg_display #(
        .SCAN_DIV    (SCAN_DIV),
        .COMMON_ANODE(1'b1)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .Q  (q),
        .SEG(seg),
        .AN (an),
        .DP (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: value held on Q one cycle earlier starts a job when
    // idle and different from the last shown value; it is shown after the job.
    int   m_qs, m_last, m_tens, m_ones, m_phase, m_left, m_cap, m_n;
    exp_t m_e;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_qs = 0; m_last = 0; m_tens = 0; m_ones = 0;
            m_phase = 0; m_left = 0; m_cap = 0; m_n = 0;
            m_e.seg = 7'h7F;
            m_e.an  = 2'b11;
        end else begin
            if (((m_n / SCAN_DIV) % 2) == 0) begin
                m_e.an  = 2'b10;
                m_e.seg = ~seg_tab[m_ones];
            end else begin
                m_e.an  = 2'b01;
                m_e.seg = (m_tens == 0) ? 7'h7F : ~seg_tab[m_tens];
            end
            case (m_phase)
                0: if (m_qs != m_last) begin
                       m_cap = m_qs; m_left = 6; m_phase = 1;
                   end
                1: begin
                       m_left--;
                       if (m_left == 0) begin
                           m_tens = m_cap / 10;
                           m_ones = m_cap % 10;
                           m_last = m_cap;
                           m_phase = 2;
                       end
                   end
                default: m_phase = 0;
            endcase
            m_qs = int'(q);
            m_n++;
        end
        exp_q.push_back(m_e);
    end

    // Monitor: the DUT presents a new registered frame after every edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame cyc=%0d: got seg=%b an=%b, need a queued expectation", cyc, seg, an);
        end else begin
            mon_e = exp_q.pop_front();
            if (seg !== mon_e.seg || an !== mon_e.an || dp !== 1'b1) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL frame cyc=%0d: got seg=%b an=%b dp=%b, need seg=%b an=%b dp=1",
                             cyc, seg, an, dp, mon_e.seg, mon_e.an);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_off(input string name);
        total++;
        if (seg !== 7'h7F || an !== 2'b11 || dp !== 1'b1) begin
            bad++;
            $display("FAIL %s: got seg=%b an=%b dp=%b, need seg=1111111 an=11 dp=1", name, seg, an, dp);
        end
    endtask

    initial begin
        int toggles;
        int bad_an;
        logic [1:0] prev_an;

        rst_n = 1'b0;
        q     = 5'd0;
        step(3);
        #1 check_off("reset_state");

        // Q=0 after release, then a held maximum value
        rst_n = 1'b1;
        step(12);
        q = 5'd31;
        step(20);

        // 9 -> 10 carries into tens together
        q = 5'd9;
        step(20);
        q = 5'd10;
        step(20);

        // Change during SHIFT: 05 commits first, then 22
        q = 5'd5;
        step(4);
        q = 5'd22;
        step(25);

        // Reset mid-SHIFT with Q=17
        q = 5'd17;
        step(4);
        rst_n = 1'b0;
        #1 check_off("reset_async");
        step(2);
        rst_n = 1'b1;
        step(15);

        // AN toggles over 40 cycles
        @(posedge clk);
        #2 prev_an = an;
        toggles = 0;
        bad_an  = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            if (an != prev_an) toggles++;
            if (an == 2'b00 || an == 2'b11) bad_an++;
            prev_an = an;
        end
        total++;
        if (toggles != 10) begin
            bad++;
            $display("FAIL an_toggles: got %0d, need 10", toggles);
        end
        total++;
        if (bad_an != 0) begin
            bad++;
            $display("FAIL an_onehot: got %0d illegal AN samples, need 0", bad_an);
        end

        // Randomized value changes with random hold times
        @(negedge clk);
        repeat (40) begin
            q = 5'($urandom_range(0, 31));
            step($urandom_range(1, 12));
        end
        step(30);

        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
